hex_select_ctrl: RTL

HEX_SELECT_CTRL -- requirements
Module: hex_select_ctrl

---
 rtl/hex_select_ctrl_pkg.sv | 34 +++
 rtl/hex_select_ctrl_if.sv | 24 ++
 rtl/hex_select_ctrl_debounce.sv | 45 ++++
 rtl/hex_select_ctrl.sv | 75 +++++++
 4 files changed

// File: rtl/hex_select_ctrl_pkg.sv
// Shared widths, display codes and value-update decoding for the hex digit selector.
package hex_select_ctrl_pkg;

  localparam int unsigned ONEHOT_W = 16;
  localparam int unsigned DIGIT_W  = 4;

  typedef logic [ONEHOT_W-1:0] onehot_t;
  typedef logic [DIGIT_W-1:0]  digit_t;

  localparam onehot_t ONEHOT_BLANK = 16'h0000;
  localparam onehot_t ONEHOT_RESET = 16'h0001;

  typedef enum logic [1:0] {
    OP_HOLD,
    OP_INC,
    OP_DEC,
    OP_LOAD
  } value_op_e;

  // Load wins outright; up and down cancel each other.
  function automatic value_op_e decode_op(input logic load, input logic up, input logic down);
    if (load)              return OP_LOAD;
    else if (up && !down)  return OP_INC;
    else if (down && !up)  return OP_DEC;
    else                   return OP_HOLD;
  endfunction

  function automatic onehot_t hex_onehot(input digit_t digit, input logic blank);
    onehot_t code;
    code = ONEHOT_RESET << digit;
    return blank ? ONEHOT_BLANK : code;
  endfunction

endpackage

// File: rtl/hex_select_ctrl_if.sv
// Button/switch inputs and display outputs of the hex digit selector as one bundle.
interface hex_select_ctrl_if;
  import hex_select_ctrl_pkg::*;

  logic    btn_up;
  logic    btn_down;
  logic    btn_load;
  logic    btn_blank;
  digit_t  sw;
  onehot_t onehot;
  digit_t  value;
  logic    changed;

  modport master (
    output btn_up, btn_down, btn_load, btn_blank, sw,
    input  onehot, value, changed
  );

  modport slave (
    input  btn_up, btn_down, btn_load, btn_blank, sw,
    output onehot, value, changed
  );

endinterface

// File: rtl/hex_select_ctrl_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter and rising-edge press pulse.
module hex_select_ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_btn,
  output logic o_press
);

  localparam int unsigned       CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_level_d;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1   <= 1'b0;
      r_sync2   <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_cnt     <= '0;
      o_press   <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      // Any cycle agreeing with the accepted level restarts the stability count.
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync2;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_level_d <= r_level;
      o_press   <= r_level & ~r_level_d;
    end
  end

endmodule

// File: rtl/hex_select_ctrl.sv
// Hex digit selector: debounced buttons step/load a 4-bit value and drive a blankable one-hot code.
module hex_select_ctrl
  import hex_select_ctrl_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic    clk,
  input  logic    rst_n,
  input  logic    btn_up,
  input  logic    btn_down,
  input  logic    btn_load,
  input  logic    btn_blank,
  input  digit_t  sw,
  output onehot_t onehot,
  output digit_t  value,
  output logic    changed
);

  logic      w_press_up;
  logic      w_press_down;
  logic      w_press_load;
  logic      w_press_blank;
  value_op_e w_op;
  digit_t    w_next_value;
  logic      w_next_blank;

  digit_t    r_sw_sync1;
  digit_t    r_sw_sync2;
  logic      r_blank;

  hex_select_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_up), .o_press(w_press_up)
  );
  hex_select_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_down), .o_press(w_press_down)
  );
  hex_select_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_load (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_load), .o_press(w_press_load)
  );
  hex_select_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_blank (
    .clk(clk), .rst_n(rst_n), .i_btn(btn_blank), .o_press(w_press_blank)
  );

  always_comb begin
    w_op         = decode_op(w_press_load, w_press_up, w_press_down);
    w_next_value = value;
    case (w_op)
      OP_LOAD: w_next_value = r_sw_sync2;
      OP_INC:  w_next_value = value + 1'b1;
      OP_DEC:  w_next_value = value - 1'b1;
      default: w_next_value = value;
    endcase
    w_next_blank = r_blank ^ w_press_blank;
  end

  // onehot is derived from the next state so it lands on the same edge as value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_sync1 <= '0;
      r_sw_sync2 <= '0;
      value      <= '0;
      r_blank    <= 1'b0;
      onehot     <= ONEHOT_RESET;
      changed    <= 1'b0;
    end else begin
      r_sw_sync1 <= sw;
      r_sw_sync2 <= r_sw_sync1;
      value      <= w_next_value;
      r_blank    <= w_next_blank;
      onehot     <= hex_onehot(w_next_value, w_next_blank);
      changed    <= (w_op != OP_HOLD) | w_press_blank;
    end
  end

endmodule
